hamming74_secded_enc_stream: RTL and testbench



---
 rtl/hamming74_secded_enc_stream.sv | 124 ++++++++++++
 tb/tb_hamming74_secded_enc_stream.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/hamming74_secded_enc_stream.sv
// Streaming Hamming(7,4) SECDED encoder: one data word in, one codeword plus an overall parity bit out per nibble, LSB nibble first.
// Optional macro HAMMING_ERR_INJECT_EN adds i_inj_mask, which corrupts the nibble-0 codeword of the word it arrives with.
module hamming74_secded_enc_stream #(
  parameter int NIBBLES = 4,
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [4*NIBBLES-1:0]   i_data,
`ifdef HAMMING_ERR_INJECT_EN
  input  logic [7:0]             i_inj_mask,
`endif
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [6:0]             o_code,
  output logic                   o_parity,
  output logic                   o_last,
  output logic [IDX_W-1:0]       o_idx
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state_q;
  logic [4*NIBBLES-1:0] word_q;
  logic [6:0]           code_q;
  logic                 parity_q;
  logic                 last_q;
  logic [IDX_W-1:0]     idx_q;

  logic                 accept;
  logic [IDX_W-1:0]     idx_inc;
  logic [3:0]           nib [NIBBLES];
  logic [6:0]           first_clean;
  logic [6:0]           first_code_d;
  logic                 first_parity_d;
  logic [6:0]           next_code_d;
  logic                 next_parity_d;
  logic                 next_last_d;

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic p1, p2, p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  generate
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
      assign nib[gi] = word_q[4*gi +: 4];
    end
  endgenerate

  assign o_valid  = (state_q == SEND);
  assign o_ready  = (state_q == IDLE) | (o_valid & i_ready & last_q);
  assign accept   = i_valid & o_ready;

  assign o_code   = code_q;
  assign o_parity = parity_q;
  assign o_last   = last_q;
  assign o_idx    = idx_q;

  // Nibble 0 is encoded straight from i_data so its codeword is ready the cycle after acceptance.
  assign first_clean = enc(i_data[3:0]);
`ifdef HAMMING_ERR_INJECT_EN
  assign first_code_d   = first_clean ^ i_inj_mask[6:0];
  assign first_parity_d = (^first_clean) ^ i_inj_mask[7];
`else
  assign first_code_d   = first_clean;
  assign first_parity_d = ^first_clean;
`endif

  assign idx_inc       = idx_q + IDX_W'(1);
  assign next_code_d   = enc(nib[idx_inc]);
  assign next_parity_d = ^next_code_d;
  assign next_last_d   = (idx_inc == IDX_W'(NIBBLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      word_q   <= '0;
      code_q   <= '0;
      parity_q <= 1'b0;
      last_q   <= 1'b0;
      idx_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q  <= SEND;
            word_q   <= i_data;
            code_q   <= first_code_d;
            parity_q <= first_parity_d;
            last_q   <= (NIBBLES == 1);
            idx_q    <= '0;
          end
        end
        SEND: begin
          if (i_ready) begin
            if (!last_q) begin
              idx_q    <= idx_inc;
              code_q   <= next_code_d;
              parity_q <= next_parity_d;
              last_q   <= next_last_d;
            end else if (i_valid) begin
              // Final handshake with a new word waiting: restart without an idle bubble.
              word_q   <= i_data;
              code_q   <= first_code_d;
              parity_q <= first_parity_d;
              last_q   <= (NIBBLES == 1);
              idx_q    <= '0;
            end else begin
              state_q  <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming74_secded_enc_stream.sv
// Directed bench for hamming74_secded_enc_stream (NIBBLES=4); codewords are checked against hand values and a reference decoder.
module tb_hamming74_secded_enc_stream;

  localparam int NIBBLES = 4;
  localparam int IDX_W   = 2;

  logic             i_clk   = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_valid = 1'b0;
  logic             i_ready = 1'b1;
  logic [15:0]      i_data  = '0;
`ifdef HAMMING_ERR_INJECT_EN
  logic [7:0]       i_inj_mask = '0;
`endif
  logic             o_ready;
  logic             o_valid;
  logic [6:0]       o_code;
  logic             o_parity;
  logic             o_last;
  logic [IDX_W-1:0] o_idx;

  int n_assert = 0;
  int n_fail   = 0;

  hamming74_secded_enc_stream #(.NIBBLES(NIBBLES)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_data    (i_data),
`ifdef HAMMING_ERR_INJECT_EN
    .i_inj_mask(i_inj_mask),
`endif
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_code    (o_code),
    .o_parity  (o_parity),
    .o_last    (o_last),
    .o_idx     (o_idx)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cw(input string tag, input logic [6:0] code, input logic par,
                        input int idx, input logic last);
    check({tag, ".valid"},  32'(o_valid),  32'(1'b1));
    check({tag, ".code"},   32'(o_code),   32'(code));
    check({tag, ".parity"}, 32'(o_parity), 32'(par));
    check({tag, ".idx"},    32'(o_idx),    32'(idx));
    check({tag, ".last"},   32'(o_last),   32'(last));
  endtask

  function automatic logic [2:0] syndrome(input logic [6:0] c);
    return {c[3] ^ c[4] ^ c[5] ^ c[6],
            c[1] ^ c[2] ^ c[5] ^ c[6],
            c[0] ^ c[2] ^ c[4] ^ c[6]};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] wd;
    logic [3:0]  nib;

    // Reset values while held in reset
    repeat (2) @(negedge i_clk);
    check("rst.valid",  32'(o_valid),  32'(1'b0));
    check("rst.code",   32'(o_code),   32'(7'h00));
    check("rst.parity", 32'(o_parity), 32'(1'b0));
    check("rst.last",   32'(o_last),   32'(1'b0));
    check("rst.idx",    32'(o_idx),    32'(0));
    i_rst_n = 1'b1;
    #1 check("rst.ready", 32'(o_ready), 32'(1'b1));
    @(negedge i_clk);

    // Word F0B1 with the sink always ready
    i_valid = 1'b1;
    i_data  = 16'hF0B1;
    check("t1.ready_idle", 32'(o_ready), 32'(1'b1));
    @(negedge i_clk);
    i_valid = 1'b0;
    chk_cw("t1.n0", 7'h07, 1'b1, 0, 1'b0);
    check("t1.ready_n0", 32'(o_ready), 32'(1'b0));
    @(negedge i_clk); chk_cw("t1.n1", 7'h55, 1'b0, 1, 1'b0);
    @(negedge i_clk); chk_cw("t1.n2", 7'h00, 1'b0, 2, 1'b0);
    @(negedge i_clk); chk_cw("t1.n3", 7'h7F, 1'b1, 3, 1'b1);
    check("t1.ready_last", 32'(o_ready), 32'(1'b1));
    @(negedge i_clk);
    check("t1.valid_end", 32'(o_valid), 32'(1'b0));
    check("t1.ready_end", 32'(o_ready), 32'(1'b1));
    check("t1.code_hold", 32'(o_code),  32'(7'h7F));

    // All 16 nibbles through the reference decoder
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < 4; k++) wd[4*k +: 4] = 4'(4*w + k);
      i_valid = 1'b1;
      i_data  = wd;
      for (int k = 0; k < 4; k++) begin
        @(negedge i_clk);
        if (k == 0) i_valid = 1'b0;
        nib = 4'(4*w + k);
        check($sformatf("ex%0d.valid", nib),  32'(o_valid), 32'(1'b1));
        check($sformatf("ex%0d.idx", nib),    32'(o_idx), 32'(k));
        check($sformatf("ex%0d.syn", nib),    32'(syndrome(o_code)), 32'(3'd0));
        check($sformatf("ex%0d.ovp", nib),    32'(^{o_parity, o_code}), 32'(1'b0));
        check($sformatf("ex%0d.data", nib),   32'({o_code[6], o_code[5], o_code[4], o_code[2]}), 32'(nib));
      end
      @(negedge i_clk);
    end

    // Backpressure for 3 cycles on idx 1 of 00B0
    i_valid = 1'b1;
    i_data  = 16'h00B0;
    @(negedge i_clk);
    i_valid = 1'b0;
    chk_cw("bp.n0", 7'h00, 1'b0, 0, 1'b0);
    @(negedge i_clk);
    chk_cw("bp.n1", 7'h55, 1'b0, 1, 1'b0);
    i_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      chk_cw($sformatf("bp.hold%0d", c), 7'h55, 1'b0, 1, 1'b0);
      check($sformatf("bp.ready%0d", c), 32'(o_ready), 32'(1'b0));
    end
    i_ready = 1'b1;
    @(negedge i_clk); chk_cw("bp.n2", 7'h00, 1'b0, 2, 1'b0);
    @(negedge i_clk); chk_cw("bp.n3", 7'h00, 1'b0, 3, 1'b1);
    @(negedge i_clk);
    check("bp.valid_end", 32'(o_valid), 32'(1'b0));

    // Back-to-back words 1111 then FFFF with i_valid held high
    i_valid = 1'b1;
    i_data  = 16'h1111;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      if (k == 0) i_data = 16'hFFFF;
      chk_cw($sformatf("b2b.a%0d", k), 7'h07, 1'b1, k, k == 3);
      check($sformatf("b2b.ready_a%0d", k), 32'(o_ready), 32'(k == 3));
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      if (k == 0) i_valid = 1'b0;
      chk_cw($sformatf("b2b.b%0d", k), 7'h7F, 1'b1, k, k == 3);
      check($sformatf("b2b.ready_b%0d", k), 32'(o_ready), 32'(k == 3));
    end
    @(negedge i_clk);
    check("b2b.valid_end", 32'(o_valid), 32'(1'b0));

    // Reset asserted at idx 2, then word 000B
    i_valid = 1'b1;
    i_data  = 16'hF0B1;
    @(negedge i_clk);
    i_valid = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    chk_cw("mr.pre", 7'h00, 1'b0, 2, 1'b0);
    i_rst_n = 1'b0;
    #1;
    check("mr.valid",  32'(o_valid),  32'(1'b0));
    check("mr.code",   32'(o_code),   32'(7'h00));
    check("mr.parity", 32'(o_parity), 32'(1'b0));
    check("mr.last",   32'(o_last),   32'(1'b0));
    check("mr.idx",    32'(o_idx),    32'(0));
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_valid = 1'b1;
    i_data  = 16'h000B;
    #1 check("mr.ready", 32'(o_ready), 32'(1'b1));
    @(negedge i_clk);
    i_valid = 1'b0;
    chk_cw("mr.n0", 7'h55, 1'b0, 0, 1'b0);
    for (int k = 1; k < 4; k++) begin
      @(negedge i_clk);
      chk_cw($sformatf("mr.n%0d", k), 7'h00, 1'b0, k, k == 3);
    end
    @(negedge i_clk);
    check("mr.valid_end", 32'(o_valid), 32'(1'b0));

`ifdef HAMMING_ERR_INJECT_EN
    // Single-bit corruption of nibble 0
    i_inj_mask = 8'h01;
    i_valid    = 1'b1;
    i_data     = 16'h0000;
    @(negedge i_clk);
    i_valid    = 1'b0;
    i_inj_mask = 8'h00;
    chk_cw("inj1.n0", 7'h01, 1'b0, 0, 1'b0);
    check("inj1.syn", 32'(syndrome(o_code)), 32'(3'd1));
    check("inj1.ovp", 32'(^{o_parity, o_code}), 32'(1'b1));
    for (int k = 1; k < 4; k++) begin
      @(negedge i_clk);
      chk_cw($sformatf("inj1.n%0d", k), 7'h00, 1'b0, k, k == 3);
    end
    @(negedge i_clk);

    // Overall-parity corruption of nibble 0
    i_inj_mask = 8'h80;
    i_valid    = 1'b1;
    @(negedge i_clk);
    i_valid    = 1'b0;
    i_inj_mask = 8'h00;
    chk_cw("inj2.n0", 7'h00, 1'b1, 0, 1'b0);
    check("inj2.syn", 32'(syndrome(o_code)), 32'(3'd0));
    check("inj2.ovp", 32'(^{o_parity, o_code}), 32'(1'b1));
    for (int k = 1; k < 4; k++) begin
      @(negedge i_clk);
      chk_cw($sformatf("inj2.n%0d", k), 7'h00, 1'b0, k, k == 3);
    end
    @(negedge i_clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
